// File: rtl/control_pkg.sv
// Shared types and constants for the ID->EX->MEM->WB control pipeline.
package control_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] ZR = REG_W'(31);

  localparam logic [1:0] ALU_OP_MEM = 2'b00;
  localparam logic [1:0] ALU_OP_CBZ = 2'b01;
  localparam logic [1:0] ALU_OP_R   = 2'b10;

  typedef struct packed {
    logic       uncondbranch;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register holding control bundle, destination and valid;
// bubble loads an all-zero, invalid entry instead of the incoming one.
module ctrl_stage_reg
  import control_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bubble,
  input  ctrl_t            ctrl_in,
  input  logic [REG_W-1:0] rd_in,
  input  logic             valid_in,
  output ctrl_t            ctrl,
  output logic [REG_W-1:0] rd,
  output logic             valid
);

  ctrl_t            ctrl_d, ctrl_q;
  logic [REG_W-1:0] rd_d, rd_q;
  logic             valid_d, valid_q;

  always_comb begin
    ctrl_d  = ctrl_in;
    rd_d    = rd_in;
    valid_d = valid_in;
    if (bubble) begin
      ctrl_d  = CTRL_BUBBLE;
      rd_d    = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= CTRL_BUBBLE;
      rd_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
    end
  end

  assign ctrl  = ctrl_q;
  assign rd    = rd_q;
  assign valid = valid_q;

endmodule

// File: rtl/control_pipeline.sv
// Carries decode control through EX/MEM/WB, raises load-use stall, resolves
// CBZ/B in MEM with a flush, and counts stall/flush cycles (saturating).
module control_pipeline
  import control_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_uncondbranch,
  input  logic             id_branch,
  input  logic             id_mem_read,
  input  logic             id_mem_to_reg,
  input  logic [1:0]       id_alu_op,
  input  logic             id_mem_write,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_r2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             mem_zero,
  output logic [1:0]       ex_alu_op,
  output logic             ex_alu_src,
  output logic [REG_W-1:0] ex_rd,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             wb_mem_to_reg,
  output logic             wb_reg_write,
  output logic [REG_W-1:0] wb_rd,
  output logic             stall,
  output logic             pc_src,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  ctrl_t            id_ctrl, ex_ctrl, mem_ctrl, wb_ctrl;
  logic [REG_W-1:0] mem_rd;
  logic             ex_valid, mem_valid, wb_valid;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;
  logic             unused_wb;

  assign id_ctrl = '{uncondbranch: id_uncondbranch, branch: id_branch,
                     mem_read: id_mem_read, mem_to_reg: id_mem_to_reg,
                     alu_op: id_alu_op, mem_write: id_mem_write,
                     alu_src: id_alu_src, reg_write: id_reg_write};

  // Branch resolution in MEM outranks the load-use check.
  assign pc_src = mem_valid & (mem_ctrl.uncondbranch | (mem_ctrl.branch & mem_zero));
  assign stall  = id_valid & ~pc_src & ~id_uncondbranch & ex_valid & ex_ctrl.mem_read &
                  (ex_rd != ZR) & ((id_rn == ex_rd) | (id_r2 == ex_rd));

  ctrl_stage_reg u_ex (
    .clk(clk), .rst_n(rst_n), .bubble(pc_src | stall | ~id_valid),
    .ctrl_in(id_ctrl), .rd_in(id_rd), .valid_in(id_valid),
    .ctrl(ex_ctrl), .rd(ex_rd), .valid(ex_valid)
  );

  ctrl_stage_reg u_mem (
    .clk(clk), .rst_n(rst_n), .bubble(pc_src),
    .ctrl_in(ex_ctrl), .rd_in(ex_rd), .valid_in(ex_valid),
    .ctrl(mem_ctrl), .rd(mem_rd), .valid(mem_valid)
  );

  ctrl_stage_reg u_wb (
    .clk(clk), .rst_n(rst_n), .bubble(1'b0),
    .ctrl_in(mem_ctrl), .rd_in(mem_rd), .valid_in(mem_valid),
    .ctrl(wb_ctrl), .rd(wb_rd), .valid(wb_valid)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (pc_src && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_alu_op     = ex_ctrl.alu_op;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign mem_mem_read  = mem_ctrl.mem_read;
  assign mem_mem_write = mem_ctrl.mem_write;
  assign wb_mem_to_reg = wb_ctrl.mem_to_reg;
  assign wb_reg_write  = wb_ctrl.reg_write;
  assign stall_count   = stall_cnt_q;
  assign flush_count   = flush_cnt_q;

  // WB only exposes write-back controls; the rest of its bundle ends here.
  assign unused_wb = ^{wb_ctrl, wb_valid};

endmodule

// File: doc/control_pipeline.md
Name: control_pipeline

Overview:
Consumer end of the decode control bundle: carries the control unit's outputs from ID through the EX, MEM and WB stage registers of the 5-stage LEGv8 pipeline. It detects load-use hazards and asserts a stall. It resolves CBZ/B in MEM by driving pc_src and flushing younger instructions. Two saturating counters record stall and flush events.

Parameters:
REG_W, 5, register index width
ZR, 31, XZR index; never a hazard source
CNT_W, 16, width of stall_count and flush_count

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous reset, active-low
id_valid  in  1  ID holds a real instruction
id_uncondbranch  in  1  decode control
id_branch  in  1  decode control
id_mem_read  in  1  decode control
id_mem_to_reg  in  1  decode control
id_alu_op  in  2  decode control
id_mem_write  in  1  decode control
id_alu_src  in  1  decode control
id_reg_write  in  1  decode control
id_rn  in  REG_W  first source register
id_r2  in  REG_W  second source (already muxed by reg2_loc)
id_rd  in  REG_W  destination register
mem_zero  in  1  ALU zero flag latched in EX/MEM
ex_alu_op  out  2  EX control
ex_alu_src  out  1  EX control
ex_rd  out  REG_W  EX destination
mem_mem_read  out  1  MEM control
mem_mem_write  out  1  MEM control
wb_mem_to_reg  out  1  WB control
wb_reg_write  out  1  WB control
wb_rd  out  REG_W  WB destination
stall  out  1  hold PC and IF/ID this cycle (combinational)
pc_src  out  1  take branch target this cycle (combinational)
stall_count  out  CNT_W  cycles with stall=1, saturating
flush_count  out  CNT_W  cycles with pc_src=1, saturating

Behaviour:
- Reset (async, rst_n=0): all stage registers, valid bits and counters clear to 0. Every output is 0.
- Stage registers: ex_*, mem_*, wb_*. Each holds the full control bundle, rd and a valid bit. A bubble is all-zero controls, rd=0, valid=0.
- pc_src = mem_valid & (mem_uncondbranch | (mem_branch & mem_zero)).
- stall = id_valid & !pc_src & !id_uncondbranch & ex_valid & ex_mem_read & (ex_rd != ZR) & ((id_rn == ex_rd) | (id_r2 == ex_rd)).
- Each rising edge:
  - WB loads MEM unconditionally.
  - MEM loads a bubble if pc_src, else EX.
  - EX loads a bubble if pc_src or stall or !id_valid, else the ID bundle.
- pc_src has priority over stall. A flush squashes the ID and EX instructions; the MEM instruction (the branch) still retires to WB.
- Latency: an ID control set appears on ex_* 1 cycle later, mem_* 2 cycles later, wb_* 3 cycles later, unless squashed.
- A load-use stall lasts exactly 1 cycle: the next cycle the load sits in MEM and no longer matches.
- Counters increment by 1 on each edge where their event is 1 and hold at all-ones.
- Reset mid-operation clears everything immediately; the first post-reset cycle has stall=0 and pc_src=0.

Decomposition:
- Shared package control_pkg holds:
  - ctrl_t packed struct (uncondbranch, branch, mem_read, mem_to_reg, alu_op[1:0], mem_write, alu_src, reg_write)
  - ALU_OP_MEM=2'b00, ALU_OP_CBZ=2'b01, ALU_OP_R=2'b10
  - ZR constant
  - CTRL_BUBBLE constant
- Sub-module ctrl_stage_reg: one stage register (ctrl_t, rd, valid) with async active-low reset and a bubble input. It is instantiated three times.

Test Plan:
- ADD X3,X1,X2 (alu_op=10, reg_write=1, rd=3) issued once -> ex_alu_op=10 at +1 cycle; wb_reg_write=1, wb_rd=3 at +3; stall=0 and pc_src=0 throughout.
- LDUR X5 (mem_read=1, mem_to_reg=1, rd=5), then ADD with id_rn=5 -> stall=1 for exactly 1 cycle; EX holds a bubble (ex_alu_op=00, valid=0); ADD reaches EX next cycle; stall_count=1.
- LDUR to rd=31 followed by a consumer with rn=31 -> stall never asserts; stall_count=0.
- CBZ (branch=1) with mem_zero=1 in MEM, two younger ADDs behind it -> pc_src=1 for 1 cycle; both ADDs never reach WB (wb_reg_write stays 0 for them); flush_count=1. Same sequence with mem_zero=0 -> pc_src=0; both ADDs retire.
- B in MEM while a load-use stall condition is present in ID/EX -> pc_src=1, stall=0, stall_count unchanged.
- Force the counter to all-ones, then hold stall conditions for 3 cycles -> stall_count stays all-ones. Assert rst_n=0 mid-stream -> all outputs 0 immediately, before the next edge.
